mont_exp_ctrl: RTL and testbench

- Sequencer for one Montgomery multiplier core, which is instantiated alongside it in the same wrapper. It runs a left-to-right square-and-multiply modular exponentiation for RSA.
- It issues one multiplication at a time and steers the core's operand muxes. It also drives the write enables of the ACC and BASE result registers.
- It owns no wide arithmetic: it holds only the exponent, a bit index and the FSM.

---
 rtl/mont_exp_ctrl_pkg.sv | 53 +++++
 rtl/mont_exp_ctrl_if.sv | 43 ++++
 rtl/mont_exp_ctrl_bit_scan.sv | 66 ++++++
 rtl/mont_exp_ctrl.sv | 134 +++++++++++++
 tb/tb_mont_exp_ctrl.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mont_exp_ctrl_pkg.sv
// rsa_pkg: definitions shared by the modular-exponentiation sequencer.
//   - operand-select codes for the Montgomery core's A/B operand muxes
//   - FSM state encoding
//   - derivation of the bit-index width from the exponent width
//   - per-state operand-select lookup helpers
package rsa_pkg;

  localparam logic [2:0] SEL_ACC  = 3'd0;
  localparam logic [2:0] SEL_BASE = 3'd1;
  localparam logic [2:0] SEL_R2   = 3'd2;
  localparam logic [2:0] SEL_ONE  = 3'd3;
  localparam logic [2:0] SEL_MSG  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TOBASE,
    ST_TOACC,
    ST_SQUARE,
    ST_MULT,
    ST_FROMM,
    ST_DONE
  } state_e;

  // Smallest index width that can hold the value word_len itself.
  function automatic int unsigned cnt_w_for(input int unsigned word_len);
    return $clog2(word_len + 1);
  endfunction

  function automatic logic is_mul_state(input state_e s);
    return (s == ST_TOBASE) || (s == ST_TOACC) || (s == ST_SQUARE) ||
           (s == ST_MULT)   || (s == ST_FROMM);
  endfunction

  function automatic logic [2:0] sel_a_of(input state_e s);
    case (s)
      ST_TOBASE: return SEL_MSG;
      ST_TOACC:  return SEL_R2;
      default:   return SEL_ACC;
    endcase
  endfunction

  function automatic logic [2:0] sel_b_of(input state_e s);
    case (s)
      ST_TOBASE: return SEL_R2;
      ST_TOACC:  return SEL_ONE;
      ST_SQUARE: return SEL_ACC;
      ST_MULT:   return SEL_BASE;
      ST_FROMM:  return SEL_ONE;
      default:   return SEL_ACC;
    endcase
  endfunction

endpackage

// File: rtl/mont_exp_ctrl_if.sv
// mont_exp_ctrl_if: bundle between the exponentiation sequencer, its host and
// the Montgomery multiplier core.
//   host side : start, exp_in, exp_len -> ; <- busy, done
//   core side : mont_start, op_a_sel, op_b_sel, acc_we, base_we -> ; <- mont_done
//   mul_count : present only when MONT_EXP_STATS_EN is defined
// Modports: slave = sequencer view, master = host/core view.
interface mont_exp_ctrl_if #(
  parameter int unsigned WORD_LEN = 512,
  parameter int unsigned CNT_W    = rsa_pkg::cnt_w_for(WORD_LEN)
);
  logic                start;
  logic [WORD_LEN-1:0] exp_in;
  logic [CNT_W-1:0]    exp_len;
  logic                busy;
  logic                done;
  logic                mont_start;
  logic                mont_done;
  logic [2:0]          op_a_sel;
  logic [2:0]          op_b_sel;
  logic                acc_we;
  logic                base_we;
`ifdef MONT_EXP_STATS_EN
  logic [15:0]         mul_count;

  modport slave (
    input  start, exp_in, exp_len, mont_done,
    output busy, done, mont_start, op_a_sel, op_b_sel, acc_we, base_we, mul_count
  );
  modport master (
    output start, exp_in, exp_len, mont_done,
    input  busy, done, mont_start, op_a_sel, op_b_sel, acc_we, base_we, mul_count
  );
`else
  modport slave (
    input  start, exp_in, exp_len, mont_done,
    output busy, done, mont_start, op_a_sel, op_b_sel, acc_we, base_we
  );
  modport master (
    output start, exp_in, exp_len, mont_done,
    input  busy, done, mont_start, op_a_sel, op_b_sel, acc_we, base_we
  );
`endif
endinterface

// File: rtl/mont_exp_ctrl_bit_scan.sv
// exp_bit_scan: exponent register and MSB-first bit-index down-counter.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load_i      : capture exp_i and the clamped length, idx = len-1
//   dec_i       : step idx down by one
//   exp_i/len_i : exponent and significant-bit count from the host
//   bit_o       : exponent bit at the current index
//   last_o      : current index is 0
//   len_zero_o  : captured (clamped) length was 0
module exp_bit_scan #(
  parameter int unsigned WORD_LEN = 512,
  parameter int unsigned CNT_W    = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic                dec_i,
  input  logic [WORD_LEN-1:0] exp_i,
  input  logic [CNT_W-1:0]    len_i,
  output logic                bit_o,
  output logic                last_o,
  output logic                len_zero_o
);

  localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(WORD_LEN);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [WORD_LEN-1:0] exp_q, exp_d;
  logic [CNT_W-1:0]    idx_q, idx_d;
  logic                len_zero_q, len_zero_d;
  logic [CNT_W-1:0]    len_clamped;
  logic [WORD_LEN-1:0] exp_shifted;

  always_comb begin
    len_clamped = (len_i > LEN_MAX) ? LEN_MAX : len_i;
    exp_d       = exp_q;
    idx_d       = idx_q;
    len_zero_d  = len_zero_q;
    if (load_i) begin
      exp_d      = exp_i;
      // Wraps to all-ones for len 0; the FSM never reads the index then.
      idx_d      = len_clamped - ONE;
      len_zero_d = (len_clamped == '0);
    end else if (dec_i) begin
      idx_d = idx_q - ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q      <= '0;
      idx_q      <= '0;
      len_zero_q <= 1'b0;
    end else begin
      exp_q      <= exp_d;
      idx_q      <= idx_d;
      len_zero_q <= len_zero_d;
    end
  end

  // Shift rather than index so an index wider than the exponent stays legal.
  assign exp_shifted = exp_q >> idx_q;
  assign bit_o       = exp_shifted[0];
  assign last_o      = (idx_q == '0);
  assign len_zero_o  = len_zero_q;

endmodule

// File: rtl/mont_exp_ctrl.sv
// mont_exp_ctrl: left-to-right square-and-multiply sequencer for one
// Montgomery multiplier core (RSA modular exponentiation).
//   clk     : system clock
//   resetn  : asynchronous active-low reset (shared with the core)
//   bus     : mont_exp_ctrl_if.slave -- host start/exp_in/exp_len, busy/done;
//             core mont_start/mont_done, op_a_sel/op_b_sel, acc_we/base_we
// Optional: define MONT_EXP_STATS_EN to add bus.mul_count, a saturating
// count of multiplications issued since the last accepted start.
module mont_exp_ctrl
  import rsa_pkg::*;
#(
  parameter int unsigned WORD_LEN = 512,
  parameter int unsigned CNT_W    = cnt_w_for(WORD_LEN)
) (
  input  logic            clk,
  input  logic            resetn,
  mont_exp_ctrl_if.slave  bus
);

  state_e     state_q, state_d;
  logic       mont_start_q;
  logic       busy_q;
  logic       done_q;
  logic [2:0] sel_a_q;
  logic [2:0] sel_b_q;

  logic accept;
  logic advance;
  logic scan_dec;
  logic exp_bit;
  logic exp_last;
  logic len_zero;

  exp_bit_scan #(
    .WORD_LEN (WORD_LEN),
    .CNT_W    (CNT_W)
  ) u_scan (
    .clk        (clk),
    .rst_n      (resetn),
    .load_i     (accept),
    .dec_i      (scan_dec),
    .exp_i      (bus.exp_in),
    .len_i      (bus.exp_len),
    .bit_o      (exp_bit),
    .last_o     (exp_last),
    .len_zero_o (len_zero)
  );

  assign accept  = (state_q == ST_IDLE) && bus.start;
  // A result arriving in the launch cycle cannot belong to this multiplication.
  assign advance = is_mul_state(state_q) && bus.mont_done && !mont_start_q;

  always_comb begin
    state_d  = state_q;
    scan_dec = 1'b0;
    case (state_q)
      ST_IDLE:   if (accept)  state_d = ST_TOBASE;
      ST_TOBASE: if (advance) state_d = ST_TOACC;
      ST_TOACC:  if (advance) state_d = len_zero ? ST_FROMM : ST_SQUARE;
      ST_SQUARE: if (advance) begin
        if (exp_bit) begin
          state_d = ST_MULT;
        end else if (exp_last) begin
          state_d = ST_FROMM;
        end else begin
          state_d  = ST_SQUARE;
          scan_dec = 1'b1;
        end
      end
      ST_MULT:   if (advance) begin
        if (exp_last) begin
          state_d = ST_FROMM;
        end else begin
          state_d  = ST_SQUARE;
          scan_dec = 1'b1;
        end
      end
      ST_FROMM:  if (advance) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it;
  // SQUARE->SQUARE re-entry relaunches the core via 'advance'.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      mont_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      sel_a_q      <= '0;
      sel_b_q      <= '0;
    end else begin
      state_q      <= state_d;
      mont_start_q <= accept || (advance && is_mul_state(state_d));
      sel_a_q      <= sel_a_of(state_d);
      sel_b_q      <= sel_b_of(state_d);
      done_q       <= (state_d == ST_DONE) && (state_q != ST_DONE);
      if (accept) begin
        busy_q <= 1'b1;
      end else if (state_q == ST_DONE) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.mont_start = mont_start_q;
  assign bus.op_a_sel   = sel_a_q;
  assign bus.op_b_sel   = sel_b_q;
  assign bus.base_we    = (state_q == ST_TOBASE) && bus.mont_done && !mont_start_q;
  assign bus.acc_we     = ((state_q == ST_TOACC) || (state_q == ST_SQUARE) ||
                           (state_q == ST_MULT)  || (state_q == ST_FROMM)) &&
                          bus.mont_done && !mont_start_q;

`ifdef MONT_EXP_STATS_EN
  logic [15:0] mul_count_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mul_count_q <= '0;
    end else if (accept) begin
      mul_count_q <= '0;
    end else if (mont_start_q && (mul_count_q != 16'hFFFF)) begin
      mul_count_q <= mul_count_q + 16'd1;
    end
  end

  assign bus.mul_count = mul_count_q;
`endif

endmodule

// File: tb/tb_mont_exp_ctrl.sv
module tb_mont_exp_ctrl;

  localparam int unsigned WL = 512;
  localparam int unsigned CW = 10;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  mont_exp_ctrl_if #(.WORD_LEN(WL), .CNT_W(CW)) bus ();

  mont_exp_ctrl #(.WORD_LEN(WL), .CNT_W(CW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  logic stub_done = 1'b0;
  logic inj_done  = 1'b0;
  assign bus.mont_done = stub_done | inj_done;

  typedef struct {
    logic [2:0] a;
    logic [2:0] b;
    logic       acc;
  } mul_t;

  typedef struct {
    int n_mul;
    int n_acc;
    int n_base;
  } done_t;

  mul_t  exp_mul_q[$];
  done_t exp_done_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Letters: B=TOBASE A=TOACC S=SQUARE M=MULT F=FROMM; encodings MSG=4 R2=2 ONE=3 ACC=0 BASE=1
  task automatic push_seq(input string s);
    done_t d;
    mul_t  m;
    d = '{0, 0, 0};
    for (int i = 0; i < s.len(); i++) begin
      case (s[i])
        "B":     m = '{3'd4, 3'd2, 1'b0};
        "A":     m = '{3'd2, 3'd3, 1'b1};
        "S":     m = '{3'd0, 3'd0, 1'b1};
        "M":     m = '{3'd0, 3'd1, 1'b1};
        default: m = '{3'd0, 3'd3, 1'b1};
      endcase
      exp_mul_q.push_back(m);
      d.n_mul++;
      if (m.acc) d.n_acc++;
      else       d.n_base++;
    end
    exp_done_q.push_back(d);
  endtask

  task automatic issue(input logic [WL-1:0] e, input logic [CW-1:0] len, input string s);
    push_seq(s);
    @(posedge clk); #1;
    bus.exp_in  = e;
    bus.exp_len = len;
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start   = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (exp_done_q.size() == 0) break;
    end
    if (exp_done_q.size() != 0) begin
      check("done_timeout", exp_done_q.size(), 0);
      exp_done_q.delete();
      exp_mul_q.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  // Stub multiplier: answers mont_done 3 cycles after each mont_start.
  initial begin
    forever begin
      @(posedge clk); #1;
      while (bus.mont_start) begin
        repeat (2) @(posedge clk);
        #1 stub_done = 1'b1;
        @(posedge clk);
        #1 stub_done = 1'b0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents an event.
  initial begin
    mul_t  cur;
    done_t dd;
    bit    have_cur;
    bit    chk_busy;
    int    r_mul, r_acc, r_base;
    have_cur = 0; chk_busy = 0; r_mul = 0; r_acc = 0; r_base = 0;
    cur = '{3'd0, 3'd0, 1'b0};
    forever begin
      @(negedge clk);
      if (!resetn) begin
        have_cur = 0; chk_busy = 0; r_mul = 0; r_acc = 0; r_base = 0;
      end else begin
        if (chk_busy) begin
          check("busy_after_done", bus.busy, 0);
          chk_busy = 0;
        end
        if (bus.mont_start) begin
          r_mul++;
          if (exp_mul_q.size() == 0) begin
            check("mont_start_expected", 0, 1);
            have_cur = 0;
          end else begin
            cur = exp_mul_q.pop_front();
            have_cur = 1;
            check("op_sel", {bus.op_a_sel, bus.op_b_sel}, {cur.a, cur.b});
          end
        end
        if (bus.acc_we || bus.base_we) begin
          if (bus.acc_we)  r_acc++;
          if (bus.base_we) r_base++;
          check("we_with_start", bus.mont_start, 0);
          check("we_kind", {bus.acc_we, bus.base_we},
                have_cur ? (cur.acc ? 2'b10 : 2'b01) : 2'b00);
          have_cur = 0;
        end
        if (bus.done) begin
          if (exp_done_q.size() == 0) begin
            check("done_expected", 0, 1);
          end else begin
            dd = exp_done_q.pop_front();
            check("n_mul", r_mul, dd.n_mul);
            check("n_acc_we", r_acc, dd.n_acc);
            check("n_base_we", r_base, dd.n_base);
            check("busy_in_done", bus.busy, 1);
`ifdef MONT_EXP_STATS_EN
            check("mul_count", bus.mul_count, dd.n_mul);
`endif
          end
          r_mul = 0; r_acc = 0; r_base = 0;
          chk_busy = 1;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    string s_all;
    int    n_sq;
    bus.start   = 1'b0;
    bus.exp_in  = '0;
    bus.exp_len = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_mont_start", bus.mont_start, 0);
    check("rst_sel", {bus.op_a_sel, bus.op_b_sel}, 0);
    check("rst_we", {bus.acc_we, bus.base_we}, 0);
    resetn = 1'b1;
    repeat (2) @(posedge clk);

    // exp_len = 0: TOBASE, TOACC, FROMM
    issue('0, 10'd0, "BAF");
    wait_done(200);

    // exp = 1011, len 4
    issue(512'hB, 10'd4, "BASMSSMSMF");
    wait_done(400);

    // Start while busy is ignored
    issue('0, 10'd0, "BAF");
    repeat (4) @(posedge clk);
    #1;
    bus.exp_in = '1; bus.exp_len = 10'd4; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(200);

    // mont_done in IDLE is ignored
    @(posedge clk); #1;
    inj_done = 1'b1;
    @(negedge clk);
    check("idle_done_we", {bus.acc_we, bus.base_we}, 0);
    check("idle_done_busy", bus.busy, 0);
    @(posedge clk); #1;
    inj_done = 1'b0;
    repeat (2) @(posedge clk);
    check("idle_done_busy2", bus.busy, 0);

    // mont_done coinciding with mont_start is ignored
    issue('0, 10'd0, "BAF");
    inj_done = 1'b1;
    @(negedge clk);
    check("coinc_start", bus.mont_start, 1);
    check("coinc_we", {bus.acc_we, bus.base_we}, 0);
    @(posedge clk); #1;
    inj_done = 1'b0;
    wait_done(200);

    // All ones, length 700 clamps to 512: 2 + 2*512 + 1 = 1027 multiplications
    s_all = "BA";
    for (int i = 0; i < 512; i++) s_all = {s_all, "SM"};
    s_all = {s_all, "F"};
    issue('1, 10'd700, s_all);
    wait_done(8000);

    // Reset during the third SQUARE of exp 1011
    issue(512'hB, 10'd4, "BASMSSMSMF");
    n_sq = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.mont_start && bus.op_a_sel == 3'd0 && bus.op_b_sel == 3'd0) n_sq++;
      if (n_sq == 3) break;
    end
    check("third_square_seen", n_sq, 3);
    #1 resetn = 1'b0;
    exp_mul_q.delete();
    exp_done_q.delete();
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_mont_start", bus.mont_start, 0);
    check("midrst_sel", {bus.op_a_sel, bus.op_b_sel}, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_we", {bus.acc_we, bus.base_we}, 0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (6) @(posedge clk);

    // Recovery: exp=1, len 1
    issue(512'h1, 10'd1, "BASMF");
    wait_done(200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
